// File: rtl/traffic_scheduler.sv
// Round-robin car-lane step engine: frame divider, lane scan FSM, frog collision check.
// Optional TRAFFIC_HIT_STICKY_EN makes o_Hit sticky until i_Hit_Clr or reset.
module traffic_scheduler #(
    parameter int unsigned             NUM_LANES   = 4,
    parameter int unsigned             GRID_W      = 20,
    parameter logic [23:0]             BASE_PERIOD = 24'd2_500_000,
    parameter logic [NUM_LANES-1:0]    LANE_DIR    = 4'b0101,
    parameter logic [5*NUM_LANES-1:0]  LANE_START  = {5'd0, 5'd19, 5'd5, 5'd12},
    parameter logic [4*NUM_LANES-1:0]  LANE_RATE   = {4'd4, 4'd3, 4'd2, 4'd1}
) (
    input  logic                       i_Clk,
    input  logic                       i_Rst_L,
    input  logic                       i_Enable,
    input  logic [1:0]                 i_Level,
    input  logic [4:0]                 i_Frog_X,
    input  logic [2:0]                 i_Frog_Row,
    input  logic                       i_Hit_Clr,
    output logic [5*NUM_LANES-1:0]     o_Car_X,
    output logic                       o_Hit,
    output logic                       o_Step_Done
);

    localparam int unsigned FRAME_W = 24;
    localparam int unsigned IDX_W   = 3;
    localparam int unsigned X_W     = 5;
    localparam int unsigned RATE_W  = 4;

    typedef enum logic [1:0] {IDLE, SCAN, CHECK, DONE} state_t;

    state_t                               state_q, state_d;
    logic [FRAME_W-1:0]                   frame_q, frame_d;
    logic [IDX_W-1:0]                     lane_q, lane_d;
    logic [1:0]                           level_q, level_d;
    logic [NUM_LANES-1:0][X_W-1:0]        car_q, car_d;
    logic [NUM_LANES-1:0][RATE_W-1:0]     cnt_q, cnt_d;
    logic                                 hit_q, hit_d;
    logic                                 done_q, done_d;
    logic                                 tick_c;
    logic                                 hit_c;

    function automatic logic [X_W-1:0] step_x(input logic [X_W-1:0] x, input logic right);
        if (right) return (x == X_W'(GRID_W - 1)) ? X_W'(0) : x + X_W'(1);
        else       return (x == X_W'(0)) ? X_W'(GRID_W - 1) : x - X_W'(1);
    endfunction

    // Level-reduced reload value, never below 1
    function automatic logic [RATE_W-1:0] eff_rate(input logic [RATE_W-1:0] rate, input logic [1:0] lvl);
        return (rate > {2'b00, lvl}) ? rate - {2'b00, lvl} : RATE_W'(1);
    endfunction

    assign tick_c = i_Enable && (frame_q == BASE_PERIOD - FRAME_W'(1));

    always_comb begin
        hit_c = 1'b0;
        for (int unsigned k = 0; k < NUM_LANES; k++) begin
            if (i_Frog_Row == IDX_W'(k + 1) && car_q[k] == i_Frog_X) hit_c = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        frame_d = frame_q;
        lane_d  = lane_q;
        level_d = level_q;
        car_d   = car_q;
        cnt_d   = cnt_q;
        hit_d   = hit_q;
        done_d  = 1'b0;

        if (i_Enable) frame_d = tick_c ? '0 : frame_q + FRAME_W'(1);

        case (state_q)
            IDLE: begin
                if (tick_c) begin
                    level_d = i_Level;
                    lane_d  = '0;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                for (int unsigned k = 0; k < NUM_LANES; k++) begin
                    if (lane_q == IDX_W'(k)) begin
                        if (cnt_q[k] == RATE_W'(1)) begin
                            cnt_d[k] = eff_rate(LANE_RATE[RATE_W*k +: RATE_W], level_q);
                            car_d[k] = step_x(car_q[k], LANE_DIR[k]);
                        end else begin
                            cnt_d[k] = cnt_q[k] - RATE_W'(1);
                        end
                    end
                end
                if (lane_q == IDX_W'(NUM_LANES - 1)) state_d = CHECK;
                else                                 lane_d  = lane_q + IDX_W'(1);
            end
            CHECK: begin
`ifdef TRAFFIC_HIT_STICKY_EN
                if (hit_c) hit_d = 1'b1;
`else
                hit_d = hit_c;
`endif
                state_d = DONE;
            end
            DONE: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

`ifdef TRAFFIC_HIT_STICKY_EN
        // Clear wins over a same-cycle set
        if (i_Hit_Clr) hit_d = 1'b0;
`endif
    end

`ifndef TRAFFIC_HIT_STICKY_EN
    logic unused_hit_clr;
    assign unused_hit_clr = i_Hit_Clr;
`endif

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state_q <= IDLE;
            frame_q <= '0;
            lane_q  <= '0;
            level_q <= '0;
            car_q   <= LANE_START;
            cnt_q   <= LANE_RATE;
            hit_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            frame_q <= frame_d;
            lane_q  <= lane_d;
            level_q <= level_d;
            car_q   <= car_d;
            cnt_q   <= cnt_d;
            hit_q   <= hit_d;
            done_q  <= done_d;
        end
    end

    assign o_Car_X     = car_q;
    assign o_Hit       = hit_q;
    assign o_Step_Done = done_q;

endmodule

// File: tb/tb_traffic_scheduler.sv
// Directed bench for traffic_scheduler with BASE_PERIOD=8: per-pass vector table plus
// hand sequences for mid-pass level change, enable gating and mid-pass reset.
module tb_traffic_scheduler;

    logic        clk = 1'b0;
    logic        rst_l;
    logic        en;
    logic [1:0]  lvl;
    logic [4:0]  fx;
    logic [2:0]  row;
    logic        clr;
    logic [19:0] car_x;
    logic        hit;
    logic        done;

    always #5 clk = ~clk;

    traffic_scheduler #(.BASE_PERIOD(24'd8)) dut (
        .i_Clk      (clk),
        .i_Rst_L    (rst_l),
        .i_Enable   (en),
        .i_Level    (lvl),
        .i_Frog_X   (fx),
        .i_Frog_Row (row),
        .i_Hit_Clr  (clr),
        .o_Car_X    (car_x),
        .o_Hit      (hit),
        .o_Step_Done(done)
    );

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [1:0]  level;
        logic [2:0]  row;
        logic [4:0]  fx;
        logic [19:0] car;
        logic        hit;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [19:0] cars(input int l0, input int l1, input int l2, input int l3);
        return {5'(l3), 5'(l2), 5'(l1), 5'(l0)};
    endfunction

    function automatic vec_t mk(input int lv, input int r, input int x, input logic [19:0] c, input logic h);
        vec_t v;
        v.level = 2'(lv); v.row = 3'(r); v.fx = 5'(x); v.car = c; v.hit = h;
        return v;
    endfunction

    task automatic wait_done(input int bound, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < bound; i++) begin
            @(posedge clk); #1;
            if (done) begin seen = 1'b1; break; end
        end
    endtask

    task automatic wait_lane0(input int bound, output bit seen);
        logic [4:0] old;
        old  = car_x[4:0];
        seen = 1'b0;
        for (int i = 0; i < bound; i++) begin
            @(posedge clk); #1;
            if (car_x[4:0] !== old) begin seen = 1'b1; break; end
        end
    endtask

    initial begin
        bit         seen;
        bit         stable;
        int         dones;
        int         lat;
        logic [19:0] old;

        rst_l = 1'b0; en = 1'b1; lvl = 2'd0; fx = 5'd0; row = 3'd0; clr = 1'b0;

        // Passes 1..8 at level 0, 9..13 at level 3
        vecs[0]  = mk(0, 1, 13, cars(13, 5, 19, 0), 1'b1);
        vecs[1]  = mk(0, 1, 13, cars(14, 4, 19, 0), 1'b0);
        vecs[2]  = mk(0, 0, 15, cars(15, 4, 0, 0), 1'b0);
        vecs[3]  = mk(0, 4, 19, cars(16, 3, 0, 19), 1'b1);
        vecs[4]  = mk(0, 5, 17, cars(17, 3, 0, 19), 1'b0);
        vecs[5]  = mk(0, 3, 1,  cars(18, 2, 1, 19), 1'b1);
        vecs[6]  = mk(0, 2, 3,  cars(19, 2, 1, 19), 1'b0);
        vecs[7]  = mk(0, 2, 1,  cars(0, 1, 1, 18), 1'b1);
        vecs[8]  = mk(3, 2, 1,  cars(1, 1, 2, 18), 1'b1);
        vecs[9]  = mk(3, 3, 3,  cars(2, 0, 3, 18), 1'b1);
        vecs[10] = mk(3, 7, 3,  cars(3, 19, 4, 18), 1'b0);
        vecs[11] = mk(3, 4, 17, cars(4, 18, 5, 17), 1'b1);
        vecs[12] = mk(3, 1, 0,  cars(5, 17, 6, 16), 1'b0);

        repeat (3) @(posedge clk);
        #1;
        check("reset_car", 32'(car_x), 32'(cars(12, 5, 19, 0)));
        check("reset_hit", 32'(hit), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        @(negedge clk) rst_l = 1'b1;

        foreach (vecs[i]) begin
            lvl = vecs[i].level; row = vecs[i].row; fx = vecs[i].fx;
            wait_done(20, seen);
            check($sformatf("pass%0d_done_seen", i + 1), 32'(seen), 32'd1);
            check($sformatf("pass%0d_car", i + 1), 32'(car_x), 32'(vecs[i].car));
            check($sformatf("pass%0d_hit", i + 1), 32'(hit), 32'(vecs[i].hit));
        end

        // Level drops 3->0 mid-SCAN: pass 14 still reloads with eff_rate 1
        lvl = 2'd3; row = 3'd0; fx = 5'd6;
        wait_lane0(20, seen);
        check("lvl_mid_start", 32'(seen), 32'd1);
        lvl = 2'd0;
        wait_done(20, seen);
        check("pass14_car", 32'(car_x), 32'(cars(6, 16, 7, 15)));
        check("pass14_hit", 32'(hit), 32'd0);
        wait_done(20, seen);
        check("pass15_car", 32'(car_x), 32'(cars(7, 15, 8, 14)));
        row = 3'd1; fx = 5'd8;
        wait_done(20, seen);
        check("pass16_car", 32'(car_x), 32'(cars(8, 15, 8, 14)));
        check("pass16_hit", 32'(hit), 32'd1);

        // Enable held low: nothing moves
        en = 1'b0; old = car_x; stable = 1'b1; dones = 0;
        repeat (100) begin
            @(posedge clk); #1;
            if (done) dones++;
            if (car_x !== old) stable = 1'b0;
        end
        check("en_low_no_done", 32'(dones), 32'd0);
        check("en_low_car_stable", 32'(stable), 32'd1);

        // Enable dropped during SCAN: pass still completes once
        row = 3'd3; fx = 5'd8; en = 1'b1;
        wait_lane0(20, seen);
        check("drop_pass_start", 32'(seen), 32'd1);
        en = 1'b0;
        wait_done(10, seen);
        check("drop_done_seen", 32'(seen), 32'd1);
        check("pass17_car", 32'(car_x), 32'(cars(9, 14, 8, 14)));
        check("pass17_hit", 32'(hit), 32'd1);
        dones = 0;
        repeat (30) begin
            @(posedge clk); #1;
            if (done) dones++;
        end
        check("drop_no_more_done", 32'(dones), 32'd0);

        // Asynchronous reset mid-SCAN, then first pass latency from release
        en = 1'b1;
        wait_lane0(20, seen);
        check("rst_pass_start", 32'(seen), 32'd1);
        @(negedge clk) rst_l = 1'b0;
        #1;
        check("midrst_car", 32'(car_x), 32'(cars(12, 5, 19, 0)));
        check("midrst_hit", 32'(hit), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        @(negedge clk) rst_l = 1'b1;
        lat = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (done) begin lat = i; break; end
        end
        check("first_done_latency", 32'(lat), 32'd14);
        check("post_rst_pass1_car", 32'(car_x), 32'(cars(13, 5, 19, 0)));
        check("post_rst_pass1_hit", 32'(hit), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
